fifo_wr_source: RTL and testbench
=================================

Name: fifo_wr_source

Overview:
- Write-domain producer for the async FIFO write port; drives Winc/Wdata and obeys the registered Wfull flag from the write-pointer/full logic.
- Accepts frames from an upstream valid/ready stream and buffers them in a 2-entry skid stage so throughput is 1 word/cycle.
- Pads any frame shorter than MIN_LEN with PAD_WORD before the next frame starts.
- Sits in the Wclk domain between the packet source and the FIFO memory/wptr logic.

Parameters:
DATA_W, 8, width of stream and FIFO data words
MIN_LEN, 4, minimum words per frame written to FIFO; 0 or 1 disables padding
PAD_WORD, 0, value of each inserted pad word (DATA_W bits)

Ports:
Wclk  in  1  write-domain clock
Wrst  in  1  reset, asynchronous, active-low
In_valid  in  1  upstream word valid
In_data  in  DATA_W  upstream word
In_last  in  1  marks last upstream word of frame
In_ready  out  1  upstream may transfer (In_valid & In_ready)
Wfull  in  1  FIFO full flag (registered, from wptr/full block)
Winc  out  1  write request to FIFO
Wdata  out  DATA_W  write data to FIFO
Busy  out  1  frame in progress (state != IDLE or skid non-empty)
Frame_done  out  1  one-cycle pulse after final word of a frame is written

Behaviour:
- Reset (Wrst low, async): FSM=IDLE, skid empty, word count=0; Winc=0, In_ready=0, Wdata=0, Busy=0, Frame_done=0. In_ready rises 1 cycle after reset release. A partial frame in flight at reset is dropped; no pad words are emitted for it.
- FIFO write: a word is written at an edge where Winc=1 and Wfull=0. Winc=1 whenever the skid output entry is valid. While Wfull=1, Winc and Wdata hold stable.
- Skid stage: two entries {data, last}. Output entry drives Wdata. In_ready is registered and equals "skid not full" and state != PAD.
- Latency: an upstream word accepted at edge N is on Wdata with Winc=1 in cycle N+1 when the skid stage was empty.
- FSM states and transitions:
  - IDLE: first accepted word moves to BODY; if that word has In_last, go straight to the end-of-frame check.
  - BODY: each accepted word increments count, which saturates at MIN_LEN.
  - End-of-frame check (on accepted In_last): count+1 < MIN_LEN -> PAD, otherwise -> IDLE with count cleared.
  - PAD: skid input = PAD_WORD, valid=1. One pad word enters per cycle the skid has space. The final pad word is tagged last. When count reaches MIN_LEN -> IDLE, count=0.
- Count width: $clog2(MIN_LEN+1), minimum 1 bit.
- Frame_done: registered pulse in the cycle after a last-tagged word is written (Winc & ~Wfull).
- Back-to-back frames: IDLE accepts the next frame's first word in the same cycle as the return from BODY/PAD. There are no bubbles in BODY.
- Wfull rising with the skid stage full: In_ready drops in the next cycle. No word is lost or duplicated.
- In_valid with In_ready=0: no transfer. Upstream holds its data.

Optional Feature:
FIFO_WR_SRC_STATS_EN
- Defined:
  - Adds outputs Frame_cnt[15:0] (increments on each Frame_done, wraps at 2^16) and Stall_cnt[15:0] (increments each cycle Winc & Wfull, saturates at 16'hFFFF).
  - Both counters clear on Wrst.
- Undefined: those ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package fifo_wr_pkg:
  - FSM state encodings IDLE/BODY/PAD as localparams.
  - Count-width function.
  - Default DATA_W.
- Sub-module fifo_wr_skid: generic 2-entry valid/ready skid buffer with {data, last} payload.
- fifo_wr_source instantiates fifo_wr_skid and holds the FSM, pad mux, count and Frame_done logic.

Test Plan:
- Reset mid-frame: send 2 of 5 words, pulse Wrst low -> Winc=0 immediately, no pad; after release next frame starts clean, Busy=0.
- Short frame, MIN_LEN=4, Wfull=0: send A1 (In_last=1) -> Wdata sequence A1,00,00,00 on 4 consecutive Winc cycles; Frame_done 1 cycle after 4th.
- Long frame: send 6 words B1..B6 (last on B6), MIN_LEN=4 -> exactly 6 writes, no pad, one Frame_done.
- Backpressure: hold Wfull=1 for 5 cycles mid-frame -> Wdata stable, In_ready low within 2 cycles, no loss/duplication; 1 word/cycle resumes after Wfull=0.
- Back-to-back frames C1(last), D1..D4(last) -> C1,00,00,00,D1..D4 written with no idle cycle when Wfull=0; two Frame_done pulses.
- With FIFO_WR_SRC_STATS_EN: 3 frames with 7 Wfull-stall cycles -> Frame_cnt=3, Stall_cnt=7.

Source files
------------

// File: rtl/fifo_wr_pkg.sv
// Shared definitions for the async-FIFO write-side producer: state encodings,
// the frame-count width helper and the default data width.
package fifo_wr_pkg;

    localparam int unsigned DefDataW = 8;

    localparam logic [1:0] EncIdle = 2'd0;
    localparam logic [1:0] EncBody = 2'd1;
    localparam logic [1:0] EncPad  = 2'd2;

    typedef enum logic [1:0] {
        StIdle = EncIdle,
        StBody = EncBody,
        StPad  = EncPad
    } wr_state_e;

    // Bits needed to count 0..min_len, never less than one.
    function automatic int unsigned cnt_width(input int unsigned min_len);
        int unsigned w;
        w = $clog2(min_len + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/fifo_wr_skid.sv
// Two-entry valid/ready skid buffer carrying a {last, data} payload.
// Entry 0 is the output entry; entry 1 only fills when entry 0 is held.
module fifo_wr_skid #(
    parameter int unsigned DataW = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    input  logic [DataW-1:0] in_data_i,
    input  logic             in_last_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    output logic [DataW-1:0] out_data_o,
    output logic             out_last_o,
    input  logic             out_ready_i,
    output logic [1:0]       occ_o
);

    logic             v0_q, v0_d, v1_q, v1_d;
    logic [DataW:0]   p0_q, p0_d, p1_q, p1_d;
    logic             push, pop;

    assign push = in_valid_i & ~v1_q;
    assign pop  = out_ready_i & v0_q;

    always_comb begin
        v0_d = v0_q;
        v1_d = v1_q;
        p0_d = p0_q;
        p1_d = p1_q;
        if (pop) begin
            v0_d = v1_q;
            p0_d = p1_q;
            v1_d = 1'b0;
        end
        // After a pop the output slot may be free again, so test the next-state valid.
        if (push) begin
            if (!v0_d) begin
                v0_d = 1'b1;
                p0_d = {in_last_i, in_data_i};
            end else begin
                v1_d = 1'b1;
                p1_d = {in_last_i, in_data_i};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v0_q <= 1'b0;
            v1_q <= 1'b0;
            p0_q <= '0;
            p1_q <= '0;
        end else begin
            v0_q <= v0_d;
            v1_q <= v1_d;
            p0_q <= p0_d;
            p1_q <= p1_d;
        end
    end

    assign in_ready_o  = ~v1_q;
    assign out_valid_o = v0_q;
    assign out_data_o  = p0_q[DataW-1:0];
    assign out_last_o  = p0_q[DataW];
    assign occ_o       = {1'b0, v0_q} + {1'b0, v1_q};

endmodule

// File: rtl/fifo_wr_source.sv
// Write-domain frame producer for the async FIFO: skid-buffered stream in, short frames
// padded to MIN_LEN. Optional FIFO_WR_SRC_STATS_EN adds Frame_cnt/Stall_cnt outputs.
module fifo_wr_source
    import fifo_wr_pkg::*;
#(
    parameter int unsigned       DATA_W   = DefDataW,
    parameter int unsigned       MIN_LEN  = 4,
    parameter logic [DATA_W-1:0] PAD_WORD = '0
) (
    input  logic              Wclk,
    input  logic              Wrst,
    input  logic              In_valid,
    input  logic [DATA_W-1:0] In_data,
    input  logic              In_last,
    output logic              In_ready,
    input  logic              Wfull,
    output logic              Winc,
    output logic [DATA_W-1:0] Wdata,
    output logic              Busy,
`ifdef FIFO_WR_SRC_STATS_EN
    output logic [15:0]       Frame_cnt,
    output logic [15:0]       Stall_cnt,
`endif
    output logic              Frame_done
);

    localparam int unsigned     CntW   = cnt_width(MIN_LEN);
    localparam logic [CntW:0]   MinLen = (CntW + 1)'(MIN_LEN);

    wr_state_e         state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [CntW:0]     cnt_inc;
    logic              in_ready_q, in_ready_d;
    logic              done_q, done_d;

    logic              skid_push, skid_last, skid_space, skid_out_last, pop, accept;
    logic [DATA_W-1:0] skid_data;
    logic [1:0]        skid_occ, occ_nxt;

    assign accept  = In_valid & in_ready_q;
    assign pop     = Winc & ~Wfull;
    assign cnt_inc = {1'b0, cnt_q} + (CntW + 1)'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        skid_push = 1'b0;
        skid_data = In_data;
        skid_last = In_last;
        unique case (state_q)
            StIdle, StBody: begin
                if (accept) begin
                    skid_push = 1'b1;
                    if (In_last) begin
                        if (cnt_inc < MinLen) begin
                            // Short frame: the pad run carries the last tag instead.
                            skid_last = 1'b0;
                            state_d   = StPad;
                            cnt_d     = cnt_inc[CntW-1:0];
                        end else begin
                            state_d = StIdle;
                            cnt_d   = '0;
                        end
                    end else begin
                        state_d = StBody;
                        if (cnt_inc <= MinLen) cnt_d = cnt_inc[CntW-1:0];
                    end
                end
            end
            StPad: begin
                skid_data = PAD_WORD;
                skid_last = 1'b0;
                if (skid_space) begin
                    skid_push = 1'b1;
                    if (cnt_inc >= MinLen) begin
                        skid_last = 1'b1;
                        state_d   = StIdle;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_inc[CntW-1:0];
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Ready is registered, so it looks ahead at next-cycle occupancy and state.
    always_comb begin
        occ_nxt    = skid_occ + {1'b0, skid_push} - {1'b0, pop};
        in_ready_d = (occ_nxt < 2'd2) && (state_d != StPad);
        done_d     = pop & skid_out_last;
    end

    always_ff @(posedge Wclk or negedge Wrst) begin
        if (!Wrst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
            done_q     <= done_d;
        end
    end

    fifo_wr_skid #(
        .DataW (DATA_W)
    ) u_skid (
        .clk_i       (Wclk),
        .rst_ni      (Wrst),
        .in_valid_i  (skid_push),
        .in_data_i   (skid_data),
        .in_last_i   (skid_last),
        .in_ready_o  (skid_space),
        .out_valid_o (Winc),
        .out_data_o  (Wdata),
        .out_last_o  (skid_out_last),
        .out_ready_i (~Wfull),
        .occ_o       (skid_occ)
    );

    assign In_ready   = in_ready_q;
    assign Busy       = (state_q != StIdle) || (skid_occ != 2'd0);
    assign Frame_done = done_q;

`ifdef FIFO_WR_SRC_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d, stall_cnt_q, stall_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q + (done_q ? 16'd1 : 16'd0);
        stall_cnt_d = stall_cnt_q;
        if (Winc && Wfull && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge Wclk or negedge Wrst) begin
        if (!Wrst) begin
            frame_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign Frame_cnt = frame_cnt_q;
    assign Stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_source.sv
// Randomised and directed bench for fifo_wr_source against a frame-level queue model.
// Define FIFO_WR_SRC_STATS_EN to also check the statistics counters.
module tb_fifo_wr_source;

    localparam int unsigned ML  = 4;
    localparam logic [7:0]  PAD = 8'h00;

    logic       Wclk = 1'b0;
    logic       Wrst = 1'b0;
    logic       In_valid = 1'b0, In_last = 1'b0, Wfull = 1'b0;
    logic [7:0] In_data = '0;
    logic       In_ready, Winc, Busy, Frame_done;
    logic [7:0] Wdata;
`ifdef FIFO_WR_SRC_STATS_EN
    logic [15:0] Frame_cnt, Stall_cnt;
`endif

    fifo_wr_source #(
        .DATA_W   (8),
        .MIN_LEN  (ML),
        .PAD_WORD (PAD)
    ) dut (
        .Wclk       (Wclk),
        .Wrst       (Wrst),
        .In_valid   (In_valid),
        .In_data    (In_data),
        .In_last    (In_last),
        .In_ready   (In_ready),
        .Wfull      (Wfull),
        .Winc       (Winc),
        .Wdata      (Wdata),
        .Busy       (Busy),
`ifdef FIFO_WR_SRC_STATS_EN
        .Frame_cnt  (Frame_cnt),
        .Stall_cnt  (Stall_cnt),
`endif
        .Frame_done (Frame_done)
    );

    always #5 Wclk = ~Wclk;

    typedef struct packed {logic [7:0] d; logic l;} wr_t;

    int         checks = 0, passes = 0, cyc = 0;
    wr_t        exp_q[$];
    logic [7:0] wr_log[$];
    int         wr_cyc[$], done_log[$];
    bit         open = 0, done_exp = 0, prev_stall = 0, rand_full = 0;
    int         open_len = 0;
    logic [7:0] prev_wdata;
    logic [15:0] frame_exp = 0, stall_exp = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    always @(posedge Wclk) cyc++;

    always @(posedge Wclk) begin
        #1;
        if (rand_full) Wfull = ($urandom_range(0, 3) == 0);
    end

    // Model: every accepted frame becomes its words, then pads up to ML, last tag on the final one.
    always @(negedge Wclk) begin
        wr_t w;
        if (!Wrst) begin
            exp_q.delete();
            open = 0; open_len = 0; done_exp = 0; prev_stall = 0;
            frame_exp = 0; stall_exp = 0;
            chk("rst_winc", Winc, 0);
            chk("rst_ready", In_ready, 0);
            chk("rst_busy", Busy, 0);
            chk("rst_done", Frame_done, 0);
            chk("rst_wdata", Wdata, 0);
        end else begin
            chk("frame_done", Frame_done, done_exp);
            if (Frame_done) done_log.push_back(cyc);
            chk("busy", Busy, (exp_q.size() != 0) || open);
            chk("winc", Winc, exp_q.size() != 0);
            if (prev_stall) chk("hold_wdata", Wdata, prev_wdata);
`ifdef FIFO_WR_SRC_STATS_EN
            chk("frame_cnt", Frame_cnt, frame_exp);
            chk("stall_cnt", Stall_cnt, stall_exp);
            if (done_exp) frame_exp++;
            if (exp_q.size() != 0 && Wfull && stall_exp != 16'hFFFF) stall_exp++;
`endif
            done_exp = 0;
            if (Winc && !Wfull) begin
                if (exp_q.size() == 0) chk("spurious_write", Winc, 0);
                else begin
                    w = exp_q.pop_front();
                    chk("wdata", Wdata, w.d);
                    done_exp = w.l;
                    wr_log.push_back(Wdata);
                    wr_cyc.push_back(cyc);
                end
            end
            prev_stall = Winc && Wfull;
            prev_wdata = Wdata;
            if (In_valid && In_ready) begin
                open_len++;
                if (In_last) begin
                    exp_q.push_back('{d: In_data, l: (open_len >= ML)});
                    for (int k = open_len; k < ML; k++) exp_q.push_back('{d: PAD, l: (k == ML - 1)});
                    open = 0; open_len = 0;
                end else begin
                    exp_q.push_back('{d: In_data, l: 1'b0});
                    open = 1;
                end
            end
        end
    end

    task automatic send_word(input logic [7:0] d, input logic l);
        int n = 0;
        In_valid = 1; In_data = d; In_last = l;
        @(negedge Wclk);
        while (!In_ready && n < 200) begin @(negedge Wclk); n++; end
        if (!In_ready) chk("ready_timeout", In_ready, 1);
        @(posedge Wclk); #1;
    endtask

    task automatic send_frame(input logic [7:0] base, input int len, input int gap);
        for (int i = 0; i < len; i++) send_word(base + 8'(i), i == len - 1);
        In_valid = 0;
        repeat (gap) begin @(posedge Wclk); #1; end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || open) && n < 300) begin @(posedge Wclk); n++; end
        chk("drain", exp_q.size(), 0);
        repeat (3) @(posedge Wclk);
        #1;
    endtask

    task automatic clear_logs();
        wr_log.delete(); wr_cyc.delete(); done_log.delete();
    endtask

    task automatic check_log(input string nm, input logic [7:0] exp_d[$], input int ndone,
                             input int extra);
        int n;
        n = wr_log.size();
        chk({nm, "_nwr"}, n, exp_d.size());
        for (int i = 0; i < n && i < exp_d.size(); i++) chk({nm, "_data"}, wr_log[i], exp_d[i]);
        if (n > 0) chk({nm, "_span"}, wr_cyc[n-1] - wr_cyc[0], n - 1 + extra);
        chk({nm, "_ndone"}, done_log.size(), ndone);
        if (n > 0 && done_log.size() > 0)
            chk({nm, "_done_time"}, done_log[done_log.size()-1], wr_cyc[n-1] + 1);
    endtask

    initial begin
        logic [7:0] e[$];
        logic       rd[$];
        repeat (3) @(posedge Wclk);
        #1 Wrst = 1;
        @(negedge Wclk) chk("ready_release_c0", In_ready, 0);
        @(negedge Wclk) chk("ready_release_c1", In_ready, 1);
        @(posedge Wclk); #1;

        clear_logs();
        send_frame(8'hA1, 1, 0);
        drain();
        e = '{8'hA1, 8'h00, 8'h00, 8'h00};
        check_log("short", e, 1, 0);

        clear_logs();
        send_frame(8'hB1, 6, 0);
        drain();
        e = '{8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6};
        check_log("long", e, 1, 0);

        clear_logs();
        send_frame(8'hC1, 1, 0);
        send_frame(8'hD1, 4, 0);
        drain();
        e = '{8'hC1, 8'h00, 8'h00, 8'h00, 8'hD1, 8'hD2, 8'hD3, 8'hD4};
        check_log("b2b", e, 2, 0);

        clear_logs();
        for (int i = 0; i < 3; i++) send_word(8'hE1 + 8'(i), 1'b0);
        Wfull = 1;
        fork
            begin
                for (int i = 3; i < 8; i++) send_word(8'hE1 + 8'(i), i == 7);
                In_valid = 0;
            end
            begin
                repeat (5) begin @(negedge Wclk); rd.push_back(In_ready); end
                @(posedge Wclk); #1 Wfull = 0;
            end
        join
        chk("bp_ready_low_c2", rd[1], 0);
        chk("bp_ready_low_c5", rd[4], 0);
        drain();
        e = '{8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hE5, 8'hE6, 8'hE7, 8'hE8};
        check_log("bp", e, 1, 5);

        send_word(8'hF1, 1'b0);
        send_word(8'hF2, 1'b0);
        In_valid = 0;
        Wrst = 0;
        #1;
        chk("rst_mid_winc", Winc, 0);
        chk("rst_mid_busy", Busy, 0);
        repeat (2) @(posedge Wclk);
        #1 Wrst = 1;
        @(posedge Wclk); #1;
        chk("rst_mid_busy_after", Busy, 0);
        clear_logs();
        send_frame(8'h51, 4, 0);
        drain();
        e = '{8'h51, 8'h52, 8'h53, 8'h54};
        check_log("after_rst", e, 1, 0);
        chk("after_rst_idle", Busy, 0);

        rand_full = 1;
        for (int f = 0; f < 30; f++)
            send_frame(8'($urandom), $urandom_range(1, 7), $urandom_range(0, 2));
        rand_full = 0;
        @(posedge Wclk); #2 Wfull = 0;
        drain();

`ifdef FIFO_WR_SRC_STATS_EN
        Wrst = 0;
        repeat (2) @(posedge Wclk);
        #1 Wrst = 1;
        @(posedge Wclk); #1;
        send_word(8'h61, 1'b0);
        send_word(8'h62, 1'b0);
        In_valid = 0;
        Wfull = 1;
        repeat (7) begin @(posedge Wclk); #1; end
        Wfull = 0;
        send_frame(8'h63, 1, 0);
        send_frame(8'h71, 2, 1);
        send_frame(8'h81, 5, 0);
        drain();
        chk("stats_frames", Frame_cnt, 3);
        chk("stats_stalls", Stall_cnt, 7);
`endif

        chk("final_busy", Busy, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
